// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: fixed-priority owner of the RTC parallel bus for the init/write/read sequencers.
// Define RTC_AUTO_REFRESH_EN to compile in the periodic read-refresh request generator.
module rtc_bus_arbiter #(
    parameter int INIT_CYCLES    = 250,
    parameter int ESC_CYCLES     = 248,
    parameter int LEER_CYCLES    = 248,
    parameter int GUARD_CYCLES   = 4,
    parameter int REFRESH_PERIOD = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_req,
    input  logic       esc_req,
    input  logic       leer_req,
    input  logic       init_a_d,
    input  logic       init_cs,
    input  logic       init_rd,
    input  logic       init_wr,
    input  logic       esc_a_d,
    input  logic       esc_cs,
    input  logic       esc_rd,
    input  logic       esc_wr,
    input  logic       leer_a_d,
    input  logic       leer_cs,
    input  logic       leer_rd,
    input  logic       leer_wr,
    output logic       do_it_init,
    output logic       do_it_escribir,
    output logic       do_it_leer,
    output logic       a_d,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic [1:0] grant,
    output logic       busy,
    output logic [2:0] pending
);
    typedef enum logic [1:0] {IDLE, RUN, GUARD} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  grant_q, grant_d;
    logic [2:0]  pending_q, pending_d;
    logic [2:0]  clr_req, win_oh;
    logic [1:0]  winner;
    logic [15:0] run_last;
    logic        refresh_wrap;
    logic        run;

    if (GUARD_CYCLES < 1 || REFRESH_PERIOD < 2) begin : g_bad_params
        $error("rtc_bus_arbiter: GUARD_CYCLES must be >=1 and REFRESH_PERIOD >=2");
    end

`ifdef RTC_AUTO_REFRESH_EN
    localparam int RW = $clog2(REFRESH_PERIOD);
    logic [RW-1:0] refresh_q, refresh_d;
    assign refresh_wrap = refresh_q == RW'(REFRESH_PERIOD - 1);
    assign refresh_d    = refresh_wrap ? '0 : refresh_q + 1'b1;
    always_ff @(posedge clk or posedge reset)
        if (reset) refresh_q <= '0;
        else       refresh_q <= refresh_d;
`else
    assign refresh_wrap = 1'b0;
`endif

    always_comb begin
        winner   = pending_q[0] ? 2'b01 : pending_q[1] ? 2'b10 : 2'b11;
        win_oh   = pending_q[0] ? 3'b001 : pending_q[1] ? 3'b010 : pending_q[2] ? 3'b100 : 3'b000;
        run_last = grant_q == 2'b01 ? 16'(INIT_CYCLES - 1) :
                   grant_q == 2'b10 ? 16'(ESC_CYCLES - 1) : 16'(LEER_CYCLES - 1);
        state_d  = state_q;
        cnt_d    = state_q == IDLE ? 16'd0 : cnt_q + 16'd1;
        grant_d  = grant_q;
        clr_req  = 3'b000;
        case (state_q)
            IDLE:  if (pending_q != 3'b000) begin
                       state_d = RUN;
                       grant_d = winner;
                       clr_req = win_oh;
                   end
            RUN:   if (cnt_q == run_last) begin
                       state_d = GUARD;
                       cnt_d   = 16'd0;
                   end
            GUARD: if (cnt_q == 16'(GUARD_CYCLES - 1)) begin
                       state_d = IDLE;
                       cnt_d   = 16'd0;
                       grant_d = 2'b00;
                   end
            default: state_d = IDLE;
        endcase
        // A request arriving on its own grant edge survives the clear and is served again
        pending_d = (pending_q & ~clr_req) | {leer_req | refresh_wrap, esc_req, init_req};
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            grant_q   <= 2'b00;
            pending_q <= 3'b000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            grant_q   <= grant_d;
            pending_q <= pending_d;
        end

    assign run            = state_q == RUN;
    assign do_it_init     = run && cnt_q == 16'd0 && grant_q == 2'b01;
    assign do_it_escribir = run && cnt_q == 16'd0 && grant_q == 2'b10;
    assign do_it_leer     = run && cnt_q == 16'd0 && grant_q == 2'b11;
    assign {a_d, cs, rd, wr} = !run              ? 4'b1111 :
                               grant_q == 2'b01 ? {init_a_d, init_cs, init_rd, init_wr} :
                               grant_q == 2'b10 ? {esc_a_d, esc_cs, esc_rd, esc_wr} :
                                                  {leer_a_d, leer_cs, leer_rd, leer_wr};
    assign grant   = grant_q;
    assign busy    = state_q != IDLE;
    assign pending = pending_q;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: scoreboard bench for rtc_bus_arbiter; expected do_it pulses are queued with their cycle.
module tb_rtc_bus_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       init_req, esc_req, leer_req;
    logic [3:0] ib = 4'b0110, eb = 4'b1001, lb = 4'b0011;
    logic       do_it_init, do_it_escribir, do_it_leer;
    logic       a_d, cs, rd, wr, busy;
    logic [1:0] grant;
    logic [2:0] pending;
    int         cyc = 0;
    int         n_tests = 0, n_fail = 0;

    typedef struct {logic [1:0] who; int cyc;} exp_t;
    exp_t sb[$];

    rtc_bus_arbiter #(.REFRESH_PERIOD(1000)) dut (
        .clk(clk), .reset(reset),
        .init_req(init_req), .esc_req(esc_req), .leer_req(leer_req),
        .init_a_d(ib[3]), .init_cs(ib[2]), .init_rd(ib[1]), .init_wr(ib[0]),
        .esc_a_d(eb[3]), .esc_cs(eb[2]), .esc_rd(eb[1]), .esc_wr(eb[0]),
        .leer_a_d(lb[3]), .leer_cs(lb[2]), .leer_rd(lb[1]), .leer_wr(lb[0]),
        .do_it_init(do_it_init), .do_it_escribir(do_it_escribir), .do_it_leer(do_it_leer),
        .a_d(a_d), .cs(cs), .rd(rd), .wr(wr),
        .grant(grant), .busy(busy), .pending(pending)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] bus_of(input logic [1:0] w);
        return w == 2'b01 ? ib : w == 2'b10 ? eb : lb;
    endfunction

    function automatic logic [2:0] oh(input logic [1:0] w);
        return w == 2'b01 ? 3'b001 : w == 2'b10 ? 3'b010 : 3'b100;
    endfunction

    task automatic push(input logic [1:0] w, input int c);
        exp_t e;
        e.who = w;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic at(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] v, output int d);
        d = cyc;
        {leer_req, esc_req, init_req} = v;
        @(negedge clk);
        {leer_req, esc_req, init_req} = 3'b000;
    endtask

    always @(negedge clk) begin
        logic [2:0] d;
        exp_t e;
        d = {do_it_leer, do_it_escribir, do_it_init};
        if (!reset && d != 3'b000) begin
            if (sb.size() == 0) check("unexpected_do_it", 32'(d), 32'(0));
            else begin
                e = sb.pop_front();
                check("do_it_who", 32'(d), 32'(oh(e.who)));
                check("do_it_cycle", 32'(cyc), 32'(e.cyc));
                check("grant_at_start", 32'(grant), 32'(e.who));
                check("pins_at_start", 32'({a_d, cs, rd, wr}), 32'(bus_of(e.who)));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d, s, lv, x;
        reset = 1'b1;
        {leer_req, esc_req, init_req} = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_pins", 32'({a_d, cs, rd, wr}), 32'hF);
        check("rst_grant", 32'(grant), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_pending", 32'(pending), 32'(0));
        check("rst_do_it", 32'({do_it_leer, do_it_escribir, do_it_init}), 32'(0));
        reset = 1'b0;
`ifdef RTC_AUTO_REFRESH_EN
        d = cyc;
        for (int k = 0; k < 5; k++) push(2'b11, d + 1001 + 1000 * k);
        at(d + 5010);
`else
        // single esc service: run window then guard
        at(10);
        pulse(3'b010, d);
        s = d + 2;
        push(2'b10, s);
        at(s + 100);
        check("esc_run_pins", 32'({a_d, cs, rd, wr}), 32'(eb));
        check("esc_run_grant", 32'(grant), 32'(2));
        check("esc_run_busy", 32'(busy), 32'(1));
        at(s + 247);
        check("esc_last_run_pins", 32'({a_d, cs, rd, wr}), 32'(eb));
        at(s + 248);
        check("guard_pins", 32'({a_d, cs, rd, wr}), 32'hF);
        check("guard_grant", 32'(grant), 32'(2));
        at(s + 251);
        check("guard_last_busy", 32'(busy), 32'(1));
        at(s + 252);
        check("idle_busy", 32'(busy), 32'(0));
        check("idle_grant", 32'(grant), 32'(0));
        // esc+leer together, then init during leer run
        at(s + 260);
        pulse(3'b110, d);
        push(2'b10, d + 2);
        push(2'b11, d + 255);
        at(d + 100);
        check("both_pending_leer", 32'(pending), 32'(3'b100));
        at(d + 255 + 50);
        pulse(3'b001, x);
        push(2'b01, d + 508);
        at(d + 255 + 100);
        check("no_preempt_pins", 32'({a_d, cs, rd, wr}), 32'(lb));
        check("no_preempt_pending", 32'(pending), 32'(3'b001));
        lv = d + 508;
        // repeated esc requests during an esc window merge into one extra service
        at(lv + 260);
        pulse(3'b010, d);
        s = d + 2;
        push(2'b10, s);
        for (int k = 1; k <= 5; k++) begin
            at(s + 10 * k);
            pulse(3'b010, x);
        end
        push(2'b10, s + 253);
        at(s + 253 + 260);
        check("merge_idle_busy", 32'(busy), 32'(0));
        check("merge_idle_pending", 32'(pending), 32'(0));
        // asynchronous reset in the middle of a run
        pulse(3'b010, d);
        s = d + 2;
        push(2'b10, s);
        at(s + 50);
        pulse(3'b100, x);
        at(s + 60);
        check("pre_rst_pending", 32'(pending), 32'(3'b100));
        at(s + 100);
        check("pre_rst_pins", 32'({a_d, cs, rd, wr}), 32'(eb));
        reset = 1'b1;
        #1;
        check("midrun_rst_pins", 32'({a_d, cs, rd, wr}), 32'hF);
        check("midrun_rst_grant", 32'(grant), 32'(0));
        check("midrun_rst_pending", 32'(pending), 32'(0));
        check("midrun_rst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (400) @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'(0));
        // without the refresh generator nothing starts on its own
        repeat (5000) @(negedge clk);
        check("no_refresh_busy", 32'(busy), 32'(0));
`endif
        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
